// File: rtl/aurora_ex_pkg.sv
// Shared encodings, widths and types for the execute stage and its iterative multiplier.
package aurora_ex_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned F7_W      = 7;
  localparam int unsigned SHAMT_W   = $clog2(XLEN);
  localparam int unsigned MUL_ITERS = 64;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SRL  = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  localparam logic [F7_W-1:0] F7_ALT    = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Pipeline control bits carried from ID/EX into EX/MEM.
  typedef struct packed {
    logic wreg_en;
    logic wmem_en;
    logic rmem_en;
    logic mem_to_reg;
    logic load;
    logic store;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, EX/MEM outputs and the upstream stall for the execute stage.
interface ex_stage_if;
  import aurora_ex_pkg::*;

  logic              WRegEn_in;
  logic              WMemEn_in;
  logic              RMemEn_in;
  logic              mem_to_reg_in;
  logic              imm_in;
  logic              load_in;
  logic              store_in;
  logic [XLEN-1:0]   R1out_in;
  logic [XLEN-1:0]   R2out_in;
  logic [XLEN-1:0]   sign_ext_in;
  logic [REG_AW-1:0] WReg1_in;
  logic [F3_W-1:0]   func3_in;
  logic [F7_W-1:0]   func7_in;

  logic              WRegEn_out;
  logic              WMemEn_out;
  logic              RMemEn_out;
  logic              mem_to_reg_out;
  logic              load_out;
  logic              store_out;
  logic [XLEN-1:0]   alu_result_out;
  logic [XLEN-1:0]   store_data_out;
  logic [REG_AW-1:0] WReg1_out;
  logic [F3_W-1:0]   func3_out;
  logic              stall_out;

  modport master (
    output WRegEn_in, WMemEn_in, RMemEn_in, mem_to_reg_in, imm_in, load_in, store_in,
    output R1out_in, R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in,
    input  WRegEn_out, WMemEn_out, RMemEn_out, mem_to_reg_out, load_out, store_out,
    input  alu_result_out, store_data_out, WReg1_out, func3_out, stall_out
  );

  modport slave (
    input  WRegEn_in, WMemEn_in, RMemEn_in, mem_to_reg_in, imm_in, load_in, store_in,
    input  R1out_in, R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in,
    output WRegEn_out, WMemEn_out, RMemEn_out, mem_to_reg_out, load_out, store_out,
    output alu_result_out, store_data_out, WReg1_out, func3_out, stall_out
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per BUSY cycle, low 64 bits of the product.
module mul_iter
  import aurora_ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_busy_c,
  output logic            o_done_c,
  output logic [XLEN-1:0] o_product
);

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MUL_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy_c    = 1'b0;
    o_done_c    = 1'b0;
    case (r_state)
      MUL_IDLE: if (i_start) w_state_nxt = MUL_BUSY;
      MUL_BUSY: begin
        o_busy_c = 1'b1;
        if (r_cnt == CNT_W'(MUL_ITERS - 1)) w_state_nxt = MUL_DONE;
      end
      // DONE always returns to IDLE, so a MUL still sitting on the inputs cannot restart here.
      MUL_DONE: begin
        o_done_c    = 1'b1;
        w_state_nxt = MUL_IDLE;
      end
      default: w_state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: if (i_start) begin
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= i_op_a;
          r_mplier <= i_op_b;
        end
        MUL_BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, multi-cycle MUL via mul_iter, and the EX/MEM pipeline register.
module ex_stage
  import aurora_ex_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  ex_stage_if.slave ex_if
);

  logic [XLEN-1:0]        w_op_a;
  logic [XLEN-1:0]        w_op_b;
  logic [XLEN-1:0]        w_alu_result;
  logic signed [XLEN-1:0] w_sra;
  logic [SHAMT_W-1:0]     w_shamt;
  logic                   w_sub;
  logic                   w_is_mul;
  logic                   w_mul_busy;
  logic                   w_mul_done;
  logic                   w_mul_start;
  logic [XLEN-1:0]        w_product;
  ex_ctrl_t               w_ctrl_in;

  ex_ctrl_t               r_ctrl;
  logic [XLEN-1:0]        r_alu_result;
  logic [XLEN-1:0]        r_store_data;
  logic [REG_AW-1:0]      r_wreg;
  logic [F3_W-1:0]        r_func3;

  ex_ctrl_t               r_mul_ctrl;
  logic [XLEN-1:0]        r_mul_store_data;
  logic [REG_AW-1:0]      r_mul_wreg;
  logic [F3_W-1:0]        r_mul_func3;

  always_comb begin
    w_ctrl_in            = '0;
    w_ctrl_in.wreg_en    = ex_if.WRegEn_in;
    w_ctrl_in.wmem_en    = ex_if.WMemEn_in;
    w_ctrl_in.rmem_en    = ex_if.RMemEn_in;
    w_ctrl_in.mem_to_reg = ex_if.mem_to_reg_in;
    w_ctrl_in.load       = ex_if.load_in;
    w_ctrl_in.store      = ex_if.store_in;
  end

  assign w_op_a  = ex_if.R1out_in;
  assign w_op_b  = ex_if.imm_in ? ex_if.sign_ext_in : ex_if.R2out_in;
  assign w_shamt = w_op_b[SHAMT_W-1:0];
  assign w_sra   = $signed(w_op_a) >>> w_shamt;
  assign w_sub   = !ex_if.imm_in && (ex_if.func7_in == F7_ALT);

  always_comb begin
    w_alu_result = '0;
    if (ex_if.load_in || ex_if.store_in) begin
      w_alu_result = ex_if.R1out_in + ex_if.sign_ext_in;
    end else begin
      case (ex_if.func3_in)
        F3_ADD:  w_alu_result = w_sub ? (w_op_a - w_op_b) : (w_op_a + w_op_b);
        F3_SLL:  w_alu_result = w_op_a << w_shamt;
        F3_SLT:  w_alu_result = ($signed(w_op_a) < $signed(w_op_b)) ? XLEN'(1) : XLEN'(0);
        F3_SLTU: w_alu_result = (w_op_a < w_op_b) ? XLEN'(1) : XLEN'(0);
        F3_XOR:  w_alu_result = w_op_a ^ w_op_b;
        F3_SRL:  w_alu_result = ex_if.func7_in[5] ? $unsigned(w_sra) : (w_op_a >> w_shamt);
        F3_OR:   w_alu_result = w_op_a | w_op_b;
        F3_AND:  w_alu_result = w_op_a & w_op_b;
        default: w_alu_result = '0;
      endcase
    end
  end

  assign w_is_mul = (ex_if.func7_in == F7_MULDIV) && (ex_if.func3_in == F3_ADD) &&
                    !ex_if.imm_in && ex_if.WRegEn_in;
  assign w_mul_start = w_is_mul && !w_mul_busy && !w_mul_done;

  // Reset gates the stall so a MUL held on the inputs during reset does not freeze upstream.
  assign ex_if.stall_out = RST && (w_mul_start || w_mul_busy);

  mul_iter u_mul_iter (
    .clk       (CLK),
    .rst_n     (RST),
    .i_start   (w_mul_start),
    .i_op_a    (ex_if.R1out_in),
    .i_op_b    (ex_if.R2out_in),
    .o_busy_c  (w_mul_busy),
    .o_done_c  (w_mul_done),
    .o_product (w_product)
  );

  // MUL side-band captured at start, replayed into EX/MEM alongside the product.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mul_ctrl       <= '0;
      r_mul_store_data <= '0;
      r_mul_wreg       <= '0;
      r_mul_func3      <= '0;
    end else if (w_mul_start) begin
      r_mul_ctrl       <= w_ctrl_in;
      r_mul_store_data <= ex_if.R2out_in;
      r_mul_wreg       <= ex_if.WReg1_in;
      r_mul_func3      <= ex_if.func3_in;
    end
  end

  // EX/MEM register: product on DONE, bubble while the multiplier owns the stage, else ALU.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ctrl       <= '0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wreg       <= '0;
      r_func3      <= '0;
    end else if (w_mul_done) begin
      r_ctrl       <= r_mul_ctrl;
      r_alu_result <= w_product;
      r_store_data <= r_mul_store_data;
      r_wreg       <= r_mul_wreg;
      r_func3      <= r_mul_func3;
    end else if (w_mul_start || w_mul_busy) begin
      r_ctrl <= '0;
    end else begin
      r_ctrl       <= w_ctrl_in;
      r_alu_result <= w_alu_result;
      r_store_data <= ex_if.R2out_in;
      r_wreg       <= ex_if.WReg1_in;
      r_func3      <= ex_if.func3_in;
    end
  end

  assign ex_if.WRegEn_out     = r_ctrl.wreg_en;
  assign ex_if.WMemEn_out     = r_ctrl.wmem_en;
  assign ex_if.RMemEn_out     = r_ctrl.rmem_en;
  assign ex_if.mem_to_reg_out = r_ctrl.mem_to_reg;
  assign ex_if.load_out       = r_ctrl.load;
  assign ex_if.store_out      = r_ctrl.store;
  assign ex_if.alu_result_out = r_alu_result;
  assign ex_if.store_data_out = r_store_data;
  assign ex_if.WReg1_out      = r_wreg;
  assign ex_if.func3_out      = r_func3;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have: RST  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ID/EX inputs: WRegEn_in, WMemEn_in, RMemEn_in, mem_to_reg_in, imm_in, load_in, store_in  in  1 each  ID/EX pipeline control.
REQ-004 SHALL have: R1out_in, R2out_in, sign_ext_in  in  64 each  operands and immediate; WReg1_in  in  5  destination; func3_in  in  3; func7_in  in  7.
REQ-005 SHALL have EX/MEM outputs: WRegEn_out, WMemEn_out, RMemEn_out, mem_to_reg_out, load_out, store_out  out  1 each, registered.
REQ-006 SHALL have: alu_result_out  out  64  result or address; store_data_out  out  64  R2 pass-through; WReg1_out  out  5; func3_out  out  3  access width for MEM; all registered.
REQ-007 SHALL have: stall_out  out  1  combinational; upstream ID/EX holds its contents while 1.

Function
REQ-008 Operand B SHALL be sign_ext_in when imm_in=1, else R2out_in.
REQ-009 load_in=1 or store_in=1 SHALL compute alu_result = R1out_in + sign_ext_in.
REQ-010 func3 decode SHALL be: 000 ADD (SUB when func7=0100000, imm_in=0), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when func7[5]=1), 110 OR, 111 AND.
REQ-011 Shift amount SHALL be operand B[5:0]; SLT signed, SLTU unsigned, result 64'd1/64'd0.
REQ-012 Add/sub SHALL wrap modulo 2^64; no overflow flag.
REQ-013 Non-MUL ops SHALL register into EX/MEM at the next rising edge (latency 1).
REQ-014 MUL (func7=0000001, func3=000, imm_in=0, WRegEn_in=1) SHALL produce low 64 bits of R1*R2 via iterative shift-add, 1 bit per cycle.
REQ-015 MUL FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE with MUL presented: stall_out=1; on edge capture operands and controls, counter:=0, go BUSY, EX/MEM loads bubble.
REQ-017 BUSY: stall_out=1, counter increments each edge, EX/MEM loads bubble; after counter=63 go DONE.
REQ-018 DONE: stall_out=0; on edge EX/MEM loads product with captured controls; go IDLE; the still-presented MUL SHALL NOT restart.
REQ-019 Bubble SHALL be all control outputs 0; data outputs don't-care but deterministic (hold).
REQ-020 MUL total: stall_out high for 65 cycles; result visible 66 edges after MUL first presented.
REQ-021 MUL with WReg1_in=0 SHALL still execute and complete normally.
REQ-022 Control inputs SHALL pass through unchanged to EX/MEM for non-MUL ops.

Reset
REQ-023 RST=0 SHALL immediately clear all registered outputs to 0, FSM to IDLE, counter to 0, independent of CLK.
REQ-024 Reset mid-MUL SHALL abort it; stall_out=0 during and after reset until a new MUL is presented.
REQ-025 First edge after RST release SHALL behave as normal IDLE operation.

Structure
REQ-026 Shared package aurora_ex_pkg SHALL hold func3/func7 encodings, FSM state type, and MUL iteration count (64).
REQ-027 Iterative multiplier SHALL be sub-module mul_iter (start, busy, done, 64-bit operands, 64-bit product); ALU and EX/MEM register stay in ex_stage.

Verification
REQ-028 ADD R1=5, R2=7, imm=0 -> alu_result_out=12 after 1 edge, WRegEn_out=1, stall_out=0 throughout.
REQ-029 SRA R1=0x8000_0000_0000_0000, R2=4, func7=0100000 -> 0xF800_0000_0000_0000; SRL same operands -> 0x0800_0000_0000_0000.
REQ-030 load R1=0x1000, sign_ext=0xFFFF_FFFF_FFFF_FFF8 -> alu_result_out=0xFF8, RMemEn_out=1, load_out=1.
REQ-031 MUL R1=0xFFFF_FFFF_FFFF_FFFF, R2=3 -> stall_out high 65 cycles, bubbles meanwhile, then alu_result_out=0xFFFF_FFFF_FFFF_FFFD with WRegEn_out=1, once only.
REQ-032 RST=0 asserted at BUSY counter=30 -> outputs 0, stall_out=0 immediately; after release, ADD 1+1 -> 2 after 1 edge.
REQ-033 SLT R1=-1, R2=1 -> 1; SLTU same -> 0; back-to-back MUL then ADD -> ADD result follows MUL result on the next edge.
